// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding and
// default timing parameters (50 MHz system clock).
package button_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DB_PRESS   = 3'd1,
      HELD       = 3'd2,
      LONG       = 3'd3,
      DB_RELEASE = 3'd4
   } btn_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES   = 50_000;      // 1 ms
   localparam int unsigned DEF_LONG_PRESS_CYCLES = 50_000_000;  // 1 s
   localparam int unsigned DEF_REPEAT_CYCLES     = 10_000_000;  // 200 ms

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Both stages reset to RESET_VALUE so the idle level is seen immediately.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clock_in,
   input  logic reset,
   input  logic raw,
   output logic synced
);

   logic stage1;

   always_ff @(posedge clock_in) begin
      if (!reset) begin
         stage1 <= RESET_VALUE;
         synced <= RESET_VALUE;
      end else begin
         stage1 <= raw;
         synced <= stage1;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Synchronise and debounce an active-low push-button; emit a debounced level
// and one-cycle press/release/long-press/auto-repeat strobes, all registered.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
   input  logic clock_in,
   input  logic reset,
   input  logic btn_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
   localparam int REP_W  = $clog2(REPEAT_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

   logic btn_sync;
   logic act;

   btn_state_t        state, state_nxt;
   logic [DB_W-1:0]   db_cnt, db_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [REP_W-1:0]  rep_cnt, rep_nxt;
   logic              long_seen, seen_nxt;
   logic              pressed_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;

   sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
      .clock_in (clock_in),
      .reset    (reset),
      .raw      (btn_n),
      .synced   (btn_sync)
   );

   assign act = ~btn_sync;

   always_ff @(posedge clock_in) begin
      if (!reset) begin
         state         <= IDLE;
         db_cnt        <= '0;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         long_seen     <= 1'b0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         state         <= state_nxt;
         db_cnt        <= db_nxt;
         hold_cnt      <= hold_nxt;
         rep_cnt       <= rep_nxt;
         long_seen     <= seen_nxt;
         pressed       <= pressed_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
         repeat_pulse  <= repeat_nxt;
      end
   end

   // A release seen at act always wins over a hold/repeat threshold in the same cycle.
   always_comb begin
      state_nxt   = state;
      db_nxt      = db_cnt;
      hold_nxt    = hold_cnt;
      rep_nxt     = rep_cnt;
      seen_nxt    = long_seen;
      pressed_nxt = pressed;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (act) begin
               state_nxt = DB_PRESS;
               db_nxt    = '0;
            end
         end
         DB_PRESS: begin
            if (!act) begin
               state_nxt = IDLE;
            end else if (db_cnt == DB_LAST) begin
               state_nxt   = HELD;
               press_nxt   = 1'b1;
               pressed_nxt = 1'b1;
               hold_nxt    = '0;
               seen_nxt    = 1'b0;
            end else begin
               db_nxt = db_cnt + DB_W'(1);
            end
         end
         HELD: begin
            if (!act) begin
               state_nxt = DB_RELEASE;
               db_nxt    = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
               seen_nxt  = 1'b1;
               rep_nxt   = '0;
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         LONG: begin
            if (!act) begin
               state_nxt = DB_RELEASE;
               db_nxt    = '0;
            end else if (rep_cnt == REP_LAST) begin
               repeat_nxt = 1'b1;
               rep_nxt    = '0;
            end else begin
               rep_nxt = rep_cnt + REP_W'(1);
            end
         end
         DB_RELEASE: begin
            // Hold/repeat counters are left untouched so a release bounce resumes the cadence.
            if (act) begin
               state_nxt = long_seen ? LONG : HELD;
            end else if (db_cnt == DB_LAST) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               pressed_nxt = 1'b0;
            end else begin
               db_nxt = db_cnt + DB_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
